// File: rtl/alu_arbiter_if.sv
// Requester/response/ALU signal bundle between the two requesters, the arbiter and the ALU.
// master = requester/ALU side, slave = arbiter side.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [7:0]  req0_opcode;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [15:0] rsp0_result;
    logic [4:0]  rsp0_psr;

    logic        req1_valid;
    logic        req1_ready;
    logic [7:0]  req1_opcode;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [15:0] rsp1_result;
    logic [4:0]  rsp1_psr;

    logic [7:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [4:0]  alu_psr;

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_opcode, req1_a, req1_b, rsp1_ready,
        output alu_result, alu_psr,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_psr,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_psr,
        input  alu_opcode, alu_a, alu_b
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_opcode, req1_a, req1_b, rsp1_ready,
        input  alu_result, alu_psr,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_psr,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_psr,
        output alu_opcode, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two valid/ready requesters, one operation at a time.
// ALU_ARB_FIXED_PRIORITY_EN: when defined, requester 0 always wins ties (default round-robin).
//
// state   | meaning
// IDLE    | arbitrate and accept one request
// ISSUE   | opcode/operands presented; ALU samples at end of cycle
// CAPTURE | ALU output valid; latched into owner's response registers
// RESP    | owner's rsp_valid high until rsp_ready
module alu_arbiter (
    input  logic         clock,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner;
    logic [7:0]  r_opcode;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [15:0] r_rsp0_result;
    logic [15:0] r_rsp1_result;
    logic [4:0]  r_rsp0_psr;
    logic [4:0]  r_rsp1_psr;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_ready0;
    logic        w_ready1;
    logic        w_accept;
    logic        w_rsp_done;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
    always_comb begin
        w_grant0 = bus.req0_valid;
        w_grant1 = bus.req1_valid & ~bus.req0_valid;
    end
`else
    logic r_last;

    // On a tie, serve whichever requester did not win last time.
    always_comb begin
        w_grant0 = bus.req0_valid;
        w_grant1 = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant0 = r_last;
            w_grant1 = ~r_last;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_ready1;
        end
    end
`endif

    // Gated by reset so no handshake can complete on a reset edge.
    assign w_ready0   = reset & (r_state == IDLE) & w_grant0;
    assign w_ready1   = reset & (r_state == IDLE) & w_grant1;
    assign w_accept   = w_ready0 | w_ready1;
    assign w_rsp_done = (r_state == RESP) & (r_owner ? bus.rsp1_ready : bus.rsp0_ready);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = ISSUE;
            ISSUE:   w_state_next = CAPTURE;
            CAPTURE: w_state_next = RESP;
            RESP:    if (w_rsp_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_owner       <= 1'b0;
            r_opcode      <= 8'h00;
            r_alu_a       <= 16'h0000;
            r_alu_b       <= 16'h0000;
            r_rsp0_result <= 16'h0000;
            r_rsp1_result <= 16'h0000;
            r_rsp0_psr    <= 5'h00;
            r_rsp1_psr    <= 5'h00;
        end else begin
            if (w_accept) begin
                r_owner  <= w_ready1;
                r_opcode <= w_ready1 ? bus.req1_opcode : bus.req0_opcode;
                r_alu_a  <= w_ready1 ? bus.req1_a      : bus.req0_a;
                r_alu_b  <= w_ready1 ? bus.req1_b      : bus.req0_b;
            end
            if (r_state == CAPTURE) begin
                if (r_owner) begin
                    r_rsp1_result <= bus.alu_result;
                    r_rsp1_psr    <= bus.alu_psr;
                end else begin
                    r_rsp0_result <= bus.alu_result;
                    r_rsp0_psr    <= bus.alu_psr;
                end
            end
        end
    end

    // Opcode 0 outside ISSUE makes the ALU idle without disturbing its flags.
    assign bus.alu_opcode  = (r_state == ISSUE) ? r_opcode : 8'h00;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;

    assign bus.req0_ready  = w_ready0;
    assign bus.req1_ready  = w_ready1;
    assign bus.rsp0_valid  = (r_state == RESP) & ~r_owner;
    assign bus.rsp1_valid  = (r_state == RESP) &  r_owner;
    assign bus.rsp0_result = r_rsp0_result;
    assign bus.rsp1_result = r_rsp1_result;
    assign bus.rsp0_psr    = r_rsp0_psr;
    assign bus.rsp1_psr    = r_rsp1_psr;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small stand-in registered ALU.
module tb_alu_arbiter;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in ALU: one-cycle registered, opcode 0 gives 0 and keeps flags.
    always @(posedge clock) begin
        if (!reset) begin
            bus.alu_result <= 16'h0000;
            bus.alu_psr    <= 5'h00;
        end else begin
            case (bus.alu_opcode)
                8'h01:   bus.alu_result <= bus.alu_a & bus.alu_b;
                8'h05:   bus.alu_result <= bus.alu_a + bus.alu_b;
                8'h09:   bus.alu_result <= bus.alu_a - bus.alu_b;
                8'h0B: begin
                    bus.alu_result <= bus.alu_a - bus.alu_b;
                    bus.alu_psr    <= {1'b0, bus.alu_a == bus.alu_b, 1'b0, bus.alu_a < bus.alu_b, 1'b0};
                end
                8'hF0:   bus.alu_result <= {bus.alu_b[7:0], bus.alu_a[7:0]};
                default: bus.alu_result <= 16'h0000;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic drive0(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.req0_opcode = op;
        bus.req0_a      = a;
        bus.req0_b      = b;
    endtask

    task automatic drive1(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.req1_opcode = op;
        bus.req1_a      = a;
        bus.req1_b      = b;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        drive0(8'h00, 16'h0000, 16'h0000);
        drive1(8'h00, 16'h0000, 16'h0000);

        // Reset values, ready held low while reset is asserted
        tick();
        tick();
        check("rst_ready0",   bus.req0_ready,  1'b0);
        check("rst_rsp0_v",   bus.rsp0_valid,  1'b0);
        check("rst_rsp1_v",   bus.rsp1_valid,  1'b0);
        check("rst_rsp0_res", bus.rsp0_result, 16'h0000);
        check("rst_rsp1_psr", bus.rsp1_psr,    5'h00);
        check("rst_alu_op",   bus.alu_opcode,  8'h00);
        check("rst_alu_a",    bus.alu_a,       16'h0000);
        check("rst_alu_b",    bus.alu_b,       16'h0000);
        bus.req0_valid = 1'b0;
        reset = 1'b1;

        // Idle ALU drive
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_alu_op", bus.alu_opcode, 8'h00);
            check("idle_ready0", bus.req0_ready, 1'b0);
        end

        // Single ADD on port 0
        drive0(8'h05, 16'h0005, 16'h0003);
        bus.req0_valid = 1'b1;
        bus.rsp0_ready = 1'b1;
        #1;
        check("add_ready0", bus.req0_ready, 1'b1);
        check("add_ready1", bus.req1_ready, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        check("add_iss_op",   bus.alu_opcode, 8'h05);
        check("add_iss_a",    bus.alu_a,      16'h0005);
        check("add_iss_b",    bus.alu_b,      16'h0003);
        check("add_iss_v",    bus.rsp0_valid, 1'b0);
        tick();
        check("add_cap_op",   bus.alu_opcode, 8'h00);
        check("add_cap_v",    bus.rsp0_valid, 1'b0);
        tick();
        check("add_rsp_v",    bus.rsp0_valid,  1'b1);
        check("add_rsp_res",  bus.rsp0_result, 16'h0008);
        check("add_rsp1_v",   bus.rsp1_valid,  1'b0);
        tick();
        check("add_done_v",   bus.rsp0_valid,  1'b0);

        // Tie arbitration with both requesters continuously valid
        do_reset();
        drive0(8'h01, 16'h00FF, 16'h0F0F);
        drive1(8'hF0, 16'h0034, 16'h0012);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < 3; k++) begin
            check("fp_ready0", bus.req0_ready, 1'b1);
            check("fp_ready1", bus.req1_ready, 1'b0);
            tick();
            check("fp_busy_ready1", bus.req1_ready, 1'b0);
            tick();
            tick();
            check("fp_rsp0_v",   bus.rsp0_valid,  1'b1);
            check("fp_rsp0_res", bus.rsp0_result, 16'h000F);
            check("fp_rsp1_v",   bus.rsp1_valid,  1'b0);
            tick();
        end
`else
        for (int k = 0; k < 4; k++) begin
            logic        g1;
            logic [15:0] res;
            g1  = (k % 2) == 1;
            res = g1 ? 16'h1234 : 16'h000F;
            check("rr_ready0", bus.req0_ready, !g1);
            check("rr_ready1", bus.req1_ready, g1);
            tick();
            tick();
            tick();
            check("rr_rsp0_v",   bus.rsp0_valid, !g1);
            check("rr_rsp1_v",   bus.rsp1_valid, g1);
            check("rr_rsp_res",  g1 ? bus.rsp1_result : bus.rsp0_result, res);
            check("rr_resp_rdy", {bus.req0_ready, bus.req1_ready}, 2'b00);
            tick();
        end
`endif
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Backpressure on port 1 while port 0 waits
        drive1(8'h0B, 16'h0007, 16'h0007);
        bus.req1_valid = 1'b1;
        bus.rsp1_ready = 1'b0;
        #1;
        check("bp_ready1", bus.req1_ready, 1'b1);
        tick();
        bus.req1_valid = 1'b0;
        drive0(8'h05, 16'h0001, 16'h0001);
        bus.req0_valid = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp1_v",  bus.rsp1_valid, 1'b1);
            check("bp_rsp1_psr", bus.rsp1_psr,  5'h08);
            check("bp_ready0",  bus.req0_ready, 1'b0);
            tick();
        end
        bus.rsp1_ready = 1'b1;
        #1;
        check("bp_last_v",    bus.rsp1_valid, 1'b1);
        tick();
        check("bp_done_v",    bus.rsp1_valid, 1'b0);
        check("bp_ready0_go", bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();
        check("bp_rsp0_v",    bus.rsp0_valid,  1'b1);
        check("bp_rsp0_res",  bus.rsp0_result, 16'h0002);
        check("bp_rsp0_psr",  bus.rsp0_psr,    5'h08);
        check("bp_rsp1_hold", bus.rsp1_result, 16'h0000);
        check("bp_psr1_hold", bus.rsp1_psr,    5'h08);
        tick();

        // Reset during CAPTURE drops the operation
        drive0(8'h09, 16'h0010, 16'h0001);
        bus.req0_valid = 1'b1;
        #1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        reset = 1'b0;
        drive0(8'h05, 16'h0005, 16'h0003);
        bus.req0_valid = 1'b1;
        tick();
        check("mr_rsp0_v",   bus.rsp0_valid,  1'b0);
        check("mr_rsp0_res", bus.rsp0_result, 16'h0000);
        check("mr_rsp0_psr", bus.rsp0_psr,    5'h00);
        check("mr_rsp1_psr", bus.rsp1_psr,    5'h00);
        check("mr_alu_op",   bus.alu_opcode,  8'h00);
        check("mr_alu_a",    bus.alu_a,       16'h0000);
        check("mr_ready0",   bus.req0_ready,  1'b0);
        reset = 1'b1;
        #1;
        check("mr_ready0_go", bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        check("mr_cap_v",    bus.rsp0_valid,  1'b0);
        tick();
        check("mr_rsp_v",    bus.rsp0_valid,  1'b1);
        check("mr_rsp_res",  bus.rsp0_result, 16'h0008);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered ALU between two independent requesters (instruction sequencer port 0, puzzle-logic port 1) using valid/ready handshakes. Accepts one operation at a time, drives the ALU operand/opcode lines, waits out the ALU's one-cycle registered latency, and captures `result`/`psrOut`. Returns them to the granted requester on a held response channel. Sits directly between the requesters and the ALU instance; the ALU runs on the same `clock` and `reset`.

## Interface
Parameters:
- none

Ports:
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_opcode` in 8: ALU opcode.
- `req0_a`, `req0_b` in 16 each: operands.
- `rsp0_valid` out 1: response for requester 0.
- `rsp0_ready` in 1: requester 0 consumes the response.
- `rsp0_result` out 16: captured ALU result.
- `rsp0_psr` out 5: captured ALU flags.
- `req1_*`, `rsp1_*`: identical to the port 0 set, for requester 1.
- `alu_opcode` out 8: to ALU `opcode`.
- `alu_a`, `alu_b` out 16 each: to ALU `rdataA` / `rdataB`.
- `alu_result` in 16: from ALU `result`.
- `alu_psr` in 5: from ALU `psrOut`.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP. A registered `owner` bit identifies the requester being served.
- IDLE:
  - Grant is decided combinationally from `req*_valid` and the `last` pointer.
  - `reqN_ready` = (state==IDLE) & grantN. At most one ready is high per cycle.
  - On valid & ready: register opcode/a/b into `alu_*`, set `owner`, update `last` = owner, go to ISSUE.
- ISSUE: `alu_*` held. The ALU samples them at the end of this cycle. Next state CAPTURE.
- CAPTURE: `alu_result`/`alu_psr` are valid. Register them into the owner's `rsp_result`/`rsp_psr`. Next state RESP.
- RESP:
  - `rspN_valid`=1 for N==owner; result and psr are held stable.
  - Stay in RESP until `rspN_ready`. On the handshake go to IDLE.
- Outside ISSUE, `alu_opcode` is driven to 8'h00, so the ALU produces 0 and leaves psr untouched. `alu_a`/`alu_b` keep their last values.
- Arbitration, round-robin: if both requesters are valid, grant the one ≠ `last`. If only one is valid, grant it.
- No arithmetic or width conversion. Values pass through unmodified; psr bits are stored as delivered by the ALU.
- The non-owner's `rsp_valid` is 0. Its `rsp_result`/`rsp_psr` keep their previous values.
- Requesters must hold opcode and operands stable while valid and not ready. The arbiter samples them only at the accept edge.

## Timing
- Reset (`reset`==0 at an edge), applied in any state including mid-operation:
  - state=IDLE, `owner`=0, `last`=1 (requester 0 wins the first tie).
  - `alu_opcode`=8'h00, `alu_a`=`alu_b`=16'h0000.
  - `rsp0/1_valid`=0, `rsp0/1_result`=16'h0000, `rsp0/1_psr`=5'h00.
  - `req0/1_ready`=0 during reset.
  - An in-flight operation is dropped; no response is produced.
- Latency:
  - Accept in cycle T.
  - ISSUE in T+1, CAPTURE in T+2.
  - `rsp_valid` high from T+3.
- Minimum issue interval: 4 cycles per operation (with `rsp_ready` held high). No pipelining of operations.
- Simultaneous events:
  - A new request arriving during ISSUE/CAPTURE/RESP waits; ready stays low.
  - The response handshake in RESP and a new request: the request is granted in the following IDLE cycle, not the same cycle.
- Backpressure: `rsp_ready` low holds RESP indefinitely with data stable. Both requesters are blocked.

## Configuration
- `ALU_ARB_FIXED_PRIORITY_EN`:
  - Defined: requester 0 always wins when both are valid; `last` is ignored (requester 1 may starve).
  - Undefined (default): round-robin as described above.

## Test plan
- **Single ADD.** Req0 opcode 8'h05, a=16'h0005, b=16'h0003, accepted cycle T. Expect `rsp0_valid` at T+3 with `rsp0_result`=16'h0008, `rsp1_valid`=0 throughout.
- **Round-robin tie.** Both valid continuously, req0 AND (8'h01, 16'h00FF & 16'h0F0F) and req1 LUI (8'hF0, a=16'h0034, b=16'h0012). Expect grants in order 0,1,0,1. `rsp0_result`=16'h000F, `rsp1_result`=16'h1234.
- **Backpressure.** Req1 CMP 8'h0B, a=b=16'h0007, `rsp1_ready` low for 5 cycles. Expect `rsp1_valid` held, `rsp1_psr[3]`=1 stable, and req0 ready=0 until the handshake.
- **Reset mid-op.** Accept req0 SUB (8'h09, 16'h0010 − 16'h0001), assert `reset`=0 during CAPTURE. Expect all outputs at reset values next cycle, no `rsp0_valid`, and the next request granted normally afterwards.
- **Fixed priority** (macro defined). Both valid for 3 operations. Expect three req0 grants; `req1_ready` never asserts.
- **Idle ALU drive.** No requests. Expect `alu_opcode`=8'h00 in every cycle after reset.
